// File: rtl/bp_history_ctrl_pkg.sv
// Shared types for the branch-prediction history controller.
// The in-flight entry records the PHT index used, the prediction, and the GHR it was made with.
package rv32i_types;

    localparam int unsigned BP_S_INDEX = 4;

    typedef struct packed {
        logic [BP_S_INDEX-1:0] index;
        logic                  pred;
        logic [BP_S_INDEX-1:0] hist;
    } bp_entry_t;

endpackage

// File: rtl/bp_history_ctrl_if.sv
// Fetch/execute/PHT-update signal bundle for bp_history_ctrl.
// The controller uses the slave modport; fetch/execute/PHT logic uses the master modport.
interface bp_history_ctrl_if
    import rv32i_types::*;
#(
    parameter int unsigned S_INDEX = BP_S_INDEX,
    parameter int unsigned DEPTH   = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic               pred_valid;
    logic               pred_ready;
    logic [31:0]        pred_pc;
    logic               pred_taken;
    logic [S_INDEX-1:0] rindex;
    logic               res_valid;
    logic               res_taken;
    logic               mispredict;
    logic               flush;
    logic [S_INDEX-1:0] windex;
    logic               increment;
    logic               decrement;
    logic [S_INDEX-1:0] ghr;
    logic [CW-1:0]      count;

    modport master (
        output pred_valid, pred_pc, pred_taken, res_valid, res_taken, flush,
        input  pred_ready, rindex, mispredict, windex, increment, decrement, ghr, count
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, res_valid, res_taken, flush,
        output pred_ready, rindex, mispredict, windex, increment, decrement, ghr, count
    );

endinterface

// File: rtl/bp_history_ctrl_queue.sv
// Circular FIFO of in-flight predictions; clear empties it in one cycle.
// Callers must not push when full or pop when empty.
module bp_queue
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  bp_entry_t                  wdata,
    output bp_entry_t                  head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    bp_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_r;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear && !rst) mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == '0);

endmodule

// File: rtl/bp_history_ctrl.sv
// gshare history controller: hashes fetch PC with the speculative GHR, tracks in-flight
// predictions, drives the PHT update port and repairs the GHR on mispredict/flush.
module bp_history_ctrl
    import rv32i_types::*;
#(
    parameter int unsigned S_INDEX = BP_S_INDEX,
    parameter int unsigned DEPTH   = 4
) (
    input logic               clk,
    input logic               rst,
    bp_history_ctrl_if.slave  bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    if (S_INDEX != BP_S_INDEX) begin : g_width_check
        $error("bp_history_ctrl: S_INDEX must equal rv32i_types::BP_S_INDEX");
    end

    bp_entry_t          head;
    bp_entry_t          wentry;
    logic               push;
    logic               pop;
    logic               clear;
    logic               full;
    logic               empty;
    logic               mis;
    logic [CW-1:0]      q_count;
    logic [S_INDEX-1:0] ghr_spec;
    logic [S_INDEX-1:0] ghr_spec_nxt;
    logic [S_INDEX-1:0] ghr_commit;
    logic [S_INDEX-1:0] ghr_commit_nxt;
    logic [S_INDEX-1:0] windex_r;
    logic               inc_r;
    logic               dec_r;

    assign pop   = bus.res_valid & ~empty;
    assign mis   = pop & (bus.res_taken != head.pred);
    assign push  = bus.pred_valid & ~full & ~mis & ~bus.flush;
    assign clear = mis | bus.flush;

    always_comb begin
        wentry       = '0;
        wentry.index = bus.pred_pc[S_INDEX+1:2] ^ ghr_spec;
        wentry.pred  = bus.pred_taken;
        wentry.hist  = ghr_spec;
    end

    always_comb begin
        ghr_commit_nxt = ghr_commit;
        if (pop) ghr_commit_nxt = {ghr_commit[S_INDEX-2:0], bus.res_taken};
    end

    // Flush restores from the committed history including a same-cycle pop; it
    // agrees with the mispredict repair value whenever both fire.
    always_comb begin
        ghr_spec_nxt = ghr_spec;
        if (bus.flush)  ghr_spec_nxt = ghr_commit_nxt;
        else if (mis)   ghr_spec_nxt = {head.hist[S_INDEX-2:0], bus.res_taken};
        else if (push)  ghr_spec_nxt = {ghr_spec[S_INDEX-2:0], bus.pred_taken};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_spec   <= '0;
            ghr_commit <= '0;
            windex_r   <= '0;
            inc_r      <= 1'b0;
            dec_r      <= 1'b0;
        end else begin
            ghr_spec   <= ghr_spec_nxt;
            ghr_commit <= ghr_commit_nxt;
            inc_r      <= pop & bus.res_taken;
            dec_r      <= pop & ~bus.res_taken;
            if (pop) windex_r <= head.index;
        end
    end

    bp_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .wdata (wentry),
        .head  (head),
        .count (q_count),
        .full  (full),
        .empty (empty)
    );

    assign bus.rindex     = wentry.index;
    assign bus.pred_ready = ~full;
    assign bus.mispredict = mis;
    assign bus.windex     = windex_r;
    assign bus.increment  = inc_r;
    assign bus.decrement  = dec_r;
    assign bus.ghr        = ghr_spec;
    assign bus.count      = q_count;

endmodule

// File: tb/tb_bp_history_ctrl.sv
// Self-checking bench for bp_history_ctrl: directed scenarios plus random traffic
// compared against a queue-based behavioural model.
module tb_bp_history_ctrl;
    localparam int unsigned S = 4;
    localparam int unsigned D = 4;

    typedef struct {
        logic [S-1:0] idx;
        logic         pred;
        logic [S-1:0] hist;
    } m_ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_history_ctrl_if #(.S_INDEX(S), .DEPTH(D)) bus ();

    bp_history_ctrl #(.S_INDEX(S), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    m_ent_t       mq[$];
    logic [S-1:0] m_spec, m_commit, m_windex;
    logic         m_inc, m_dec;

    function automatic logic m_mis();
        return bus.res_valid && mq.size() != 0 && (bus.res_taken != mq[0].pred);
    endfunction

    task automatic drive(input logic pv, input logic [31:0] pc, input logic pt,
                         input logic rv, input logic rt, input logic fl);
        bus.pred_valid = pv; bus.pred_pc = pc; bus.pred_taken = pt;
        bus.res_valid = rv;  bus.res_taken = rt; bus.flush = fl;
    endtask

    // Advance the model by one clock using the currently driven inputs, then clock the DUT.
    task automatic tick();
        m_ent_t h;
        logic p, mis, psh;
        int unsigned sz;
        h = '{idx: '0, pred: 1'b0, hist: '0};
        sz  = mq.size();
        p   = bus.res_valid && sz != 0;
        if (p) h = mq[0];
        mis = p && (bus.res_taken != h.pred);
        psh = bus.pred_valid && sz != D && !mis && !bus.flush;
        if (rst) begin
            mq.delete(); m_spec = '0; m_commit = '0; m_windex = '0; m_inc = 0; m_dec = 0;
        end else begin
            if (p) begin
                m_commit = {m_commit[S-2:0], bus.res_taken};
                m_windex = h.idx; m_inc = bus.res_taken; m_dec = !bus.res_taken;
                void'(mq.pop_front());
            end else begin
                m_inc = 0; m_dec = 0;
            end
            if (bus.flush) begin
                mq.delete(); m_spec = m_commit;
            end else if (mis) begin
                mq.delete(); m_spec = {h.hist[S-2:0], bus.res_taken};
            end else if (psh) begin
                mq.push_back('{idx: bus.pred_pc[S+1:2] ^ m_spec, pred: bus.pred_taken, hist: m_spec});
                m_spec = {m_spec[S-2:0], bus.pred_taken};
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (bus.count !== 3'd0)     $display("FAIL reset_count: got %0d exp 0", bus.count); else passed++;
        total++; if (bus.ghr !== 4'd0)       $display("FAIL reset_ghr: got %b exp 0000", bus.ghr); else passed++;
        total++; if (bus.pred_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", bus.pred_ready); else passed++;
        total++; if (bus.increment !== 1'b0 || bus.decrement !== 1'b0)
            $display("FAIL reset_update: got inc=%b dec=%b exp 0/0", bus.increment, bus.decrement); else passed++;
        total++; if (bus.windex !== 4'd0)    $display("FAIL reset_windex: got %0d exp 0", bus.windex); else passed++;
        total++; if (bus.mispredict !== 1'b0) $display("FAIL reset_mispredict: got %b exp 0", bus.mispredict); else passed++;
    endtask

    task automatic test_index_push();
        do_reset();
        drive(1, 32'h0000_0010, 1, 0, 0, 0); #1;
        total++; if (bus.rindex !== 4'd4) $display("FAIL index_rindex: got %0d exp 4", bus.rindex); else passed++;
        tick();
        drive(0, 32'h0, 0, 0, 0, 0);
        total++; if (bus.ghr !== 4'b0001) $display("FAIL index_ghr: got %b exp 0001", bus.ghr); else passed++;
        total++; if (bus.count !== 3'd1)  $display("FAIL index_count: got %0d exp 1", bus.count); else passed++;
    endtask

    task automatic test_full();
        logic [3:0] bits;
        bits = 4'b1011;
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            drive(1, 32'h100 + 32'(i * 4), bits[i], 0, 0, 0);
            tick();
        end
        total++; if (bus.count !== 3'd4)      $display("FAIL full_count: got %0d exp 4", bus.count); else passed++;
        total++; if (bus.pred_ready !== 1'b0) $display("FAIL full_ready: got %b exp 0", bus.pred_ready); else passed++;
        total++; if (bus.ghr !== 4'b1011)     $display("FAIL full_ghr: got %b exp 1011", bus.ghr); else passed++;
        drive(1, 32'h200, 0, 0, 0, 0);
        tick();
        total++; if (bus.count !== 3'd4 || bus.ghr !== 4'b1011)
            $display("FAIL full_held: got count=%0d ghr=%b exp 4/1011", bus.count, bus.ghr); else passed++;
        drive(1, 32'h200, 0, 1, 1, 0); #1;
        total++; if (bus.mispredict !== 1'b0) $display("FAIL full_pop_mis: got %b exp 0", bus.mispredict); else passed++;
        tick();
        drive(0, 32'h0, 0, 0, 0, 0);
        total++; if (bus.pred_ready !== 1'b1 || bus.count !== 3'd3)
            $display("FAIL full_after_pop: got ready=%b count=%0d exp 1/3", bus.pred_ready, bus.count); else passed++;
    endtask

    task automatic test_match_pop();
        do_reset();
        drive(1, 32'h0000_0010, 1, 0, 0, 0); tick();
        drive(1, 32'h0000_0040, 0, 0, 0, 0); tick();
        drive(0, 32'h0, 0, 1, 1, 0); #1;
        total++; if (bus.mispredict !== 1'b0) $display("FAIL match_mis: got %b exp 0", bus.mispredict); else passed++;
        tick();
        drive(0, 32'h0, 0, 0, 0, 0);
        total++; if (bus.windex !== 4'd4 || bus.increment !== 1'b1 || bus.decrement !== 1'b0)
            $display("FAIL match_update: got w=%0d inc=%b dec=%b exp 4/1/0", bus.windex, bus.increment, bus.decrement); else passed++;
        total++; if (bus.ghr !== 4'b0010) $display("FAIL match_spec: got %b exp 0010", bus.ghr); else passed++;
        drive(0, 32'h0, 0, 0, 0, 1); tick();
        drive(0, 32'h0, 0, 0, 0, 0);
        total++; if (bus.ghr !== 4'b0001 || bus.count !== 3'd0)
            $display("FAIL match_commit: got ghr=%b count=%0d exp 0001/0", bus.ghr, bus.count); else passed++;
    endtask

    task automatic test_mispredict();
        do_reset();
        drive(1, 32'h0000_0020, 1, 0, 0, 0); tick();
        drive(1, 32'h0000_0024, 1, 0, 0, 0); tick();
        drive(1, 32'h0000_0028, 0, 0, 0, 0); tick();
        drive(1, 32'h0000_002c, 1, 1, 0, 0); #1;
        total++; if (bus.mispredict !== 1'b1) $display("FAIL mis_comb: got %b exp 1", bus.mispredict); else passed++;
        tick();
        drive(0, 32'h0, 0, 0, 0, 0);
        total++; if (bus.count !== 3'd0 || bus.ghr !== 4'b0000)
            $display("FAIL mis_repair: got count=%0d ghr=%b exp 0/0000", bus.count, bus.ghr); else passed++;
        total++; if (bus.decrement !== 1'b1 || bus.increment !== 1'b0 || bus.windex !== 4'd8)
            $display("FAIL mis_update: got w=%0d inc=%b dec=%b exp 8/0/1", bus.windex, bus.increment, bus.decrement); else passed++;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h300 + 32'(i * 4), 1, 0, 0, 0); tick();
        end
        drive(0, 32'h0, 0, 1, 1, 0); tick();
        drive(0, 32'h0, 0, 1, 1, 0); tick();
        drive(0, 32'h0, 0, 0, 0, 0);
        total++; if (bus.count !== 3'd2 || bus.ghr !== 4'b1111)
            $display("FAIL flush_pre: got count=%0d ghr=%b exp 2/1111", bus.count, bus.ghr); else passed++;
        drive(1, 32'h400, 0, 0, 0, 1); tick();
        drive(0, 32'h0, 0, 0, 0, 0);
        total++; if (bus.count !== 3'd0 || bus.ghr !== 4'b0011)
            $display("FAIL flush_restore: got count=%0d ghr=%b exp 0/0011", bus.count, bus.ghr); else passed++;
        // flush together with a matching pop: the pop commits and updates
        drive(1, 32'h0000_0014, 1, 0, 0, 0); tick();
        drive(1, 32'h0000_0018, 0, 1, 1, 1); tick();
        drive(0, 32'h0, 0, 0, 0, 0);
        total++; if (bus.count !== 3'd0 || bus.ghr !== 4'b0111 || bus.increment !== 1'b1)
            $display("FAIL flush_pop: got count=%0d ghr=%b inc=%b exp 0/0111/1", bus.count, bus.ghr, bus.increment); else passed++;
    endtask

    task automatic test_empty_res();
        do_reset();
        drive(1, 32'h0000_0014, 1, 0, 0, 0); tick();
        drive(0, 32'h0, 0, 1, 1, 0); tick();
        drive(0, 32'h0, 0, 1, 0, 0); #1;
        total++; if (bus.mispredict !== 1'b0) $display("FAIL empty_mis: got %b exp 0", bus.mispredict); else passed++;
        tick();
        drive(0, 32'h0, 0, 0, 0, 0);
        total++; if (bus.increment !== 1'b0 || bus.decrement !== 1'b0 || bus.windex !== 4'd5)
            $display("FAIL empty_update: got w=%0d inc=%b dec=%b exp 5/0/0", bus.windex, bus.increment, bus.decrement); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h500 + 32'(i * 4), 1, 0, 0, 0); tick();
        end
        total++; if (bus.count !== 3'd3) $display("FAIL rstmid_pre: got %0d exp 3", bus.count); else passed++;
        rst = 1'b1;
        drive(1, 32'h600, 1, 1, 0, 0); tick();
        rst = 1'b0;
        drive(0, 32'h0, 0, 0, 0, 0);
        total++; if (bus.count !== 3'd0 || bus.ghr !== 4'd0 || bus.increment !== 1'b0 || bus.decrement !== 1'b0)
            $display("FAIL rstmid_post: got count=%0d ghr=%b inc=%b dec=%b exp 0/0000/0/0",
                     bus.count, bus.ghr, bus.increment, bus.decrement); else passed++;
    endtask

    task automatic test_random();
        logic pv, pt, rv, rt, fl;
        logic [31:0] pc;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            pv = ($urandom_range(0, 9) < 6);
            pc = $urandom();
            pt = $urandom_range(0, 1) == 1;
            rv = ($urandom_range(0, 9) < 4);
            if (mq.size() != 0 && $urandom_range(0, 9) < 7) rt = mq[0].pred;
            else rt = $urandom_range(0, 1) == 1;
            fl = ($urandom_range(0, 99) < 3);
            rst = ($urandom_range(0, 199) == 0);
            drive(pv, pc, pt, rv, rt, fl); #1;
            total++; if (bus.rindex !== (pc[S+1:2] ^ m_spec))
                $display("FAIL rnd_rindex[%0d]: got %0d exp %0d", n, bus.rindex, pc[S+1:2] ^ m_spec); else passed++;
            total++; if (bus.pred_ready !== (mq.size() != D))
                $display("FAIL rnd_ready[%0d]: got %b exp %b", n, bus.pred_ready, mq.size() != D); else passed++;
            total++; if (bus.mispredict !== m_mis())
                $display("FAIL rnd_mis[%0d]: got %b exp %b", n, bus.mispredict, m_mis()); else passed++;
            tick();
            total++; if (bus.count !== 3'(mq.size()) || bus.ghr !== m_spec)
                $display("FAIL rnd_state[%0d]: got count=%0d ghr=%b exp %0d/%b", n, bus.count, bus.ghr, mq.size(), m_spec); else passed++;
            total++; if (bus.increment !== m_inc || bus.decrement !== m_dec || bus.windex !== m_windex)
                $display("FAIL rnd_update[%0d]: got w=%0d inc=%b dec=%b exp %0d/%b/%b",
                         n, bus.windex, bus.increment, bus.decrement, m_windex, m_inc, m_dec); else passed++;
        end
        rst = 1'b0;
    endtask

    initial begin
        drive(0, 32'h0, 0, 0, 0, 0);
        mq.delete(); m_spec = '0; m_commit = '0; m_windex = '0; m_inc = 0; m_dec = 0;
        test_reset();
        test_index_push();
        test_full();
        test_match_pop();
        test_mispredict();
        test_flush();
        test_empty_res();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
